// File: rtl/tohost_monitor.sv
// tohost_monitor: riscv-tests tohost responder with watchdog.
// Ports: clk/rst; req_* bus in; req_ready/rsp_* bus out; done/pass/fail_testnum/timeout/cycle_count status.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_1008,
    parameter int unsigned TIMEOUT     = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_testnum,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_PASS    = 2'd1;
    localparam logic [1:0] S_FAIL    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [31:0] LAST = 32'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [31:0] tohost_q;
    logic [31:0] rd_next;
    logic [31:0] status_word;
    logic        acc;
    logic        load;
    logic        hit_tohost;
    logic        hit_status;
    logic        running;
    logic        st_tohost;
    logic        term_store;
    logic        unused_addr;

    // Byte offset within the word is irrelevant to the decode.
    assign unused_addr = ^req_addr[1:0];

    // No wait states: everything outside reset is accepted at once.
    assign req_ready = !rst;

    assign acc        = req_valid && req_ready;
    assign load       = acc && !req_we;
    assign hit_tohost = req_addr[31:2] == TOHOST_ADDR[31:2];
    assign hit_status = req_addr[31:2] == STATUS_ADDR[31:2];
    assign running    = state == S_RUN;
    assign st_tohost  = acc && req_we && hit_tohost && running;
    assign term_store = st_tohost && req_wdata[0];

    assign status_word = {fail_testnum[28:0], timeout, pass, done};

    always_comb begin
        rd_next = '0;
        unique case (1'b1)
            hit_tohost: rd_next = tohost_q;
            hit_status: rd_next = status_word;
            default:    rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            tohost_q     <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_testnum <= '0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
        end else begin
            rsp_valid <= load;
            if (load)
                rsp_rdata <= rd_next;

            if (running) begin
                // The terminating cycle itself still counts as a RUN cycle.
                cycle_count <= cycle_count + 32'd1;
                if (st_tohost)
                    tohost_q <= req_wdata;
                // A terminating store beats a watchdog expiry in the same cycle.
                if (term_store && req_wdata == 32'd1) begin
                    state <= S_PASS;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else if (term_store) begin
                    state        <= S_FAIL;
                    done         <= 1'b1;
                    fail_testnum <= req_wdata[31:1];
                end else if (cycle_count == LAST) begin
                    state   <= S_TIMEOUT;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: table, directed and random checks of tohost_monitor.
// Every cycle is compared against a tohost-convention reference model.
module tb_tohost_monitor;

    localparam int unsigned TO = 20;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        done;
    logic        pass;
    logic [30:0] fail_testnum;
    logic        timeout;
    logic [31:0] cycle_count;

    tohost_monitor #(
        .TOHOST_ADDR(32'h0000_1000),
        .STATUS_ADDR(32'h0000_1008),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .done(done),
        .pass(pass),
        .fail_testnum(fail_testnum),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: the test outcome as the tohost convention defines it.
    logic        m_done, m_pass, m_to, m_rv;
    logic [30:0] m_fnum;
    logic [31:0] m_tohost, m_rd;
    int unsigned m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        logic [31:0] sw;
        logic hit_t, hit_s, st;
        if (r) begin
            m_done = 0; m_pass = 0; m_to = 0; m_rv = 0;
            m_fnum = 0; m_tohost = 0; m_rd = 0; m_cnt = 0;
            return;
        end
        hit_t = (a / 4) == (32'h1000 / 4);
        hit_s = (a / 4) == (32'h1008 / 4);
        sw = {m_fnum[28:0], m_to, m_pass, m_done};
        m_rv = v && !we;
        if (m_rv) m_rd = hit_t ? m_tohost : (hit_s ? sw : 32'd0);
        if (!m_done) begin
            st = v && we && hit_t;
            if (st) m_tohost = d;
            if (st && d == 1) begin
                m_done = 1; m_pass = 1;
            end else if (st && d % 2 == 1) begin
                m_done = 1; m_fnum = 31'(d / 2);
            end else if (m_cnt == TO - 1) begin
                m_done = 1; m_to = 1;
            end
            m_cnt++;
        end
    endtask

    // One clock cycle: drive, check ready mid-cycle, then compare all outputs.
    task automatic cyc(input logic r, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
        rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        #2;
        chk("req_ready", 32'(req_ready), 32'(!r));
        @(posedge clk);
        model(r, v, we, a, d);
        #1;
        chk("done", 32'(done), 32'(m_done));
        chk("pass", 32'(pass), 32'(m_pass));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("fail_testnum", 32'(fail_testnum), 32'(m_fnum));
        chk("cycle_count", cycle_count, m_cnt);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_rdata", rsp_rdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        r, v, we;
        logic [31:0] a, d;
        logic        e_done, e_pass, e_to;
        logic [30:0] e_fnum;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int k;
        //           r  v  we addr          wdata        dn ps to fnum rv rd
        tbl[0]  = '{1, 0, 0, 32'h0,        32'h0,       0, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 1, 32'h1000,     32'h4,       0, 0, 0, 0, 0, 32'h0};
        tbl[2]  = '{0, 1, 0, 32'h1000,     32'h0,       0, 0, 0, 0, 1, 32'h4};
        tbl[3]  = '{0, 1, 1, 32'h1000,     32'h7,       1, 0, 0, 3, 0, 32'h4};
        tbl[4]  = '{0, 1, 1, 32'h1000,     32'h1,       1, 0, 0, 3, 0, 32'h4};
        tbl[5]  = '{0, 1, 0, 32'h1000,     32'h0,       1, 0, 0, 3, 1, 32'h7};
        tbl[6]  = '{0, 1, 0, 32'h1008,     32'h0,       1, 0, 0, 3, 1, 32'h19};
        tbl[7]  = '{0, 1, 0, 32'h2000,     32'h0,       1, 0, 0, 3, 1, 32'h0};
        tbl[8]  = '{0, 0, 0, 32'h0,        32'h0,       1, 0, 0, 3, 0, 32'h0};
        tbl[9]  = '{1, 0, 0, 32'h0,        32'h0,       0, 0, 0, 0, 0, 32'h0};
        tbl[10] = '{0, 1, 1, 32'h1000,     32'hB,       1, 0, 0, 5, 0, 32'h0};
        tbl[11] = '{0, 1, 0, 32'h1008,     32'h0,       1, 0, 0, 5, 1, 32'h29};
        tbl[12] = '{0, 1, 1, 32'h1008,     32'hFFFF,    1, 0, 0, 5, 0, 32'h29};
        tbl[13] = '{1, 1, 1, 32'h1000,     32'h1,       0, 0, 0, 0, 0, 32'h0};
        tbl[14] = '{0, 0, 0, 32'h0,        32'h0,       0, 0, 0, 0, 0, 32'h0};

        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d);
            chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
            chk("tbl_pass", 32'(pass), 32'(tbl[i].e_pass));
            chk("tbl_timeout", 32'(timeout), 32'(tbl[i].e_to));
            chk("tbl_fnum", 32'(fail_testnum), 32'(tbl[i].e_fnum));
            chk("tbl_rv", 32'(rsp_valid), 32'(tbl[i].e_rv));
            chk("tbl_rd", rsp_rdata, tbl[i].e_rd);
        end

        // Pass at cycle 10: count freezes at 11.
        cyc(1, 0, 0, 0, 0);
        idle(10);
        chk("pre_pass_cnt", cycle_count, 32'd10);
        cyc(0, 1, 1, 32'h1000, 32'h1);
        chk("pass_done", 32'(done), 32'd1);
        chk("pass_pass", 32'(pass), 32'd1);
        idle(3);
        chk("pass_cnt_frozen", cycle_count, 32'd11);

        // Reset with a request present while in PASS; the request is dropped.
        cyc(1, 1, 1, 32'h1000, 32'h7);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", cycle_count, 32'd0);
        cyc(0, 1, 0, 32'h1000, 32'h0);
        chk("rst_dropped", rsp_rdata, 32'd0);
        chk("rst_cnt_run", cycle_count, 32'd1);

        // Syscall-style even value keeps running.
        cyc(0, 1, 1, 32'h1000, 32'h4);
        chk("even_done", 32'(done), 32'd0);

        // Watchdog: expiry after exactly TO RUN cycles.
        cyc(1, 0, 0, 0, 0);
        idle(TO - 1);
        chk("to_not_yet", 32'(done), 32'd0);
        idle(1);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_done", 32'(done), 32'd1);
        idle(2);
        chk("to_cnt_frozen", cycle_count, 32'(TO));

        // Store in the expiry cycle wins over the watchdog.
        cyc(1, 0, 0, 0, 0);
        idle(TO - 1);
        cyc(0, 1, 1, 32'h1000, 32'h1);
        chk("exp_pass", 32'(pass), 32'd1);
        chk("exp_timeout", 32'(timeout), 32'd0);

        // Randomized traffic.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            k = int'($urandom_range(0, 4));
            case (k)
                0, 1: a = 32'h1000 | 32'($urandom_range(0, 3));
                2: a = 32'h1008;
                3: a = 32'h1004;
                default: a = $urandom;
            endcase
            k = int'($urandom_range(0, 7));
            if (k == 0) d = 32'h1;
            else if (k == 1) d = $urandom | 32'h1;
            else d = $urandom & 32'hFFFF_FFFE;
            cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) < 5),
                $urandom_range(0, 1) == 1, a, d);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
